sys_ctrl: RTL and testbench

SYS_CTRL -- requirements
Module: sys_ctrl

---
 rtl/sys_ctrl_pkg.sv | 26 ++
 rtl/sys_ctrl_tx_seq.sv | 69 ++++++
 rtl/sys_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sys_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared opcodes, ALU operand addresses and FSM state encoding for sys_ctrl
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR     = 8'hAA;
  localparam logic [7:0] CMD_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU    = 8'hCC;
  localparam logic [7:0] CMD_ALU_FN = 8'hDD;

  localparam logic [7:0] ALU_A_ADDR = 8'd0;
  localparam logic [7:0] ALU_B_ADDR = 8'd1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_SEND,
    S_TX_WAIT
  } state_e;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// rtl/sys_ctrl_tx_seq.sv - byte sequencer feeding the UART TX: reply buffer, byte count, busy tracking
module sys_ctrl_tx_seq #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic [2*DATA_W-1:0] load_data,
  input  logic [1:0]          load_cnt,
  input  logic                send_en,
  input  logic                wait_en,
  input  logic                tx_busy,
  output logic                fire,
  output logic                done,
  output logic                more,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_vld
);

  logic [2*DATA_W-1:0] buf_q, buf_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                seen_q, seen_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                vld_q, vld_d;

  assign fire    = send_en && !tx_busy;
  assign done    = wait_en && seen_q && !tx_busy;
  assign more    = (cnt_q != 2'd0);
  assign tx_data = data_q;
  assign tx_vld  = vld_q;

  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    seen_d = seen_q;
    data_d = data_q;
    vld_d  = 1'b0;
    if (load_en) begin
      buf_d = load_data;
      cnt_d = load_cnt;
    end else if (fire) begin
      // Low byte goes first; shift the next one down for the following send.
      data_d = buf_q[DATA_W-1:0];
      vld_d  = 1'b1;
      buf_d  = {{DATA_W{1'b0}}, buf_q[2*DATA_W-1:DATA_W]};
      cnt_d  = cnt_q - 2'd1;
      seen_d = 1'b0;
    end else if (wait_en && tx_busy) begin
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      cnt_q  <= 2'd0;
      seen_q <= 1'b0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - UART command decoder driving register-file, ALU and TX reply path
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   RX_P_DATA,
  input  logic                RX_D_VLD,
  input  logic [DATA_W-1:0]   RdData,
  input  logic                RdData_Valid,
  input  logic [2*DATA_W-1:0] ALU_OUT,
  input  logic                OUT_Valid,
  input  logic                TX_busy,
  output logic                WrEn,
  output logic                RdEn,
  output logic [ADDR_W-1:0]   Address,
  output logic [DATA_W-1:0]   WrData,
  output logic                ALU_EN,
  output logic [3:0]          ALU_FUN,
  output logic [DATA_W-1:0]   TX_P_DATA,
  output logic                TX_D_VLD
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [3:0]          alu_fun_q, alu_fun_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                alu_en_q, alu_en_d;

  logic                tx_load;
  logic [2*DATA_W-1:0] tx_load_data;
  logic [1:0]          tx_load_cnt;
  logic                tx_send, tx_wait;
  logic                tx_fire, tx_done, tx_more;

  assign WrEn    = wr_en_q;
  assign RdEn    = rd_en_q;
  assign ALU_EN  = alu_en_q;
  assign Address = addr_q;
  assign WrData  = wr_data_q;
  assign ALU_FUN = alu_fun_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    alu_fun_d    = alu_fun_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    alu_en_d     = 1'b0;
    tx_load      = 1'b0;
    tx_load_data = '0;
    tx_load_cnt  = 2'd0;
    tx_send      = 1'b0;
    tx_wait      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_W'(CMD_WR))          state_d = S_WR_ADDR;
          else if (RX_P_DATA == DATA_W'(CMD_RD))     state_d = S_RD_ADDR;
          else if (RX_P_DATA == DATA_W'(CMD_ALU))    state_d = S_ALU_A;
          else if (RX_P_DATA == DATA_W'(CMD_ALU_FN)) state_d = S_ALU_FUN;
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          rd_en_d = 1'b1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (RdData_Valid) begin
          tx_load      = 1'b1;
          tx_load_data = {{DATA_W{1'b0}}, RdData};
          tx_load_cnt  = 2'd1;
          state_d      = S_TX_SEND;
        end
      end
      S_ALU_A: begin
        if (RX_D_VLD) begin
          addr_d    = ADDR_W'(ALU_A_ADDR);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = S_ALU_B;
        end
      end
      S_ALU_B: begin
        // A byte landing right behind operand A would double-pulse WrEn; hold it off.
        if (RX_D_VLD && !wr_en_q) begin
          addr_d    = ADDR_W'(ALU_B_ADDR);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = S_ALU_FUN;
        end
      end
      S_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          state_d   = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (OUT_Valid) begin
          tx_load      = 1'b1;
          tx_load_data = ALU_OUT;
          tx_load_cnt  = 2'd2;
          state_d      = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        tx_send = 1'b1;
        if (tx_fire) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        tx_wait = 1'b1;
        if (tx_done) state_d = tx_more ? S_TX_SEND : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_fun_q <= 4'd0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
    end
  end

  sys_ctrl_tx_seq #(.DATA_W(DATA_W)) u_tx_seq (
    .clk       (clk),
    .rst       (rst),
    .load_en   (tx_load),
    .load_data (tx_load_data),
    .load_cnt  (tx_load_cnt),
    .send_en   (tx_send),
    .wait_en   (tx_wait),
    .tx_busy   (TX_busy),
    .fire      (tx_fire),
    .done      (tx_done),
    .more      (tx_more),
    .tx_data   (TX_P_DATA),
    .tx_vld    (TX_D_VLD)
  );

endmodule

// File: tb/tb_sys_ctrl.sv
// tb/tb_sys_ctrl.sv - scoreboard bench for sys_ctrl with register-file, ALU and UART TX responders
module tb_sys_ctrl;

  localparam logic [7:0] K_WR  = 8'd1;
  localparam logic [7:0] K_RD  = 8'd2;
  localparam logic [7:0] K_ALU = 8'd3;
  localparam logic [7:0] K_TX  = 8'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RdData = 8'h00;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_Valid = 1'b0;
  logic        TX_busy = 1'b0;
  logic        WrEn, RdEn, ALU_EN, TX_D_VLD;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, TX_P_DATA;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sb_q[$];
  logic [7:0]  rd_reply = 8'h00;
  logic [15:0] alu_reply = 16'h0000;
  int          alu_lat = 6;
  int          alu_delay = -1;
  int          busy_cnt = 0;
  logic        prev_wr = 1'b0, prev_rd = 1'b0, prev_alu = 1'b0, prev_tx = 1'b0;

  always #5 clk = ~clk;

  sys_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .ALU_OUT      (ALU_OUT),
    .OUT_Valid    (OUT_Valid),
    .TX_busy      (TX_busy),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [7:0] kind, input logic [7:0] addr, input logic [15:0] data);
    return {kind, addr, data};
  endfunction

  task automatic match(input string tag, input logic [31:0] act);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_unexpected"}, act, 32'h0);
    end else begin
      e = sb_q.pop_front();
      chk(tag, act, e);
    end
  endtask

  // Monitor and responders share one process so their ordering within a cycle is fixed.
  always @(negedge clk) begin
    logic busy_now;
    busy_now = TX_busy;
    RdData_Valid = 1'b0;
    OUT_Valid = 1'b0;
    if (!rst) begin
      if (WrEn) begin
        chk("wren_gap", {31'b0, prev_wr}, 32'h0);
        match("wr", ev(K_WR, {4'h0, Address}, {8'h00, WrData}));
      end
      if (RdEn) begin
        chk("rden_gap", {31'b0, prev_rd}, 32'h0);
        match("rd", ev(K_RD, {4'h0, Address}, 16'h0000));
        RdData = rd_reply;
        RdData_Valid = 1'b1;
      end
      if (ALU_EN) begin
        chk("aluen_gap", {31'b0, prev_alu}, 32'h0);
        match("alu", ev(K_ALU, 8'h00, {12'h000, ALU_FUN}));
        alu_delay = alu_lat;
      end
      if (TX_D_VLD) begin
        chk("txvld_gap", {31'b0, prev_tx}, 32'h0);
        chk("tx_while_busy", {31'b0, busy_now}, 32'h0);
        match("tx", ev(K_TX, 8'h00, {8'h00, TX_P_DATA}));
        busy_cnt = 4;
        TX_busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) TX_busy = 1'b0;
      end
      if (!ALU_EN) begin
        if (alu_delay > 0) begin
          alu_delay--;
        end else if (alu_delay == 0) begin
          ALU_OUT = alu_reply;
          OUT_Valid = 1'b1;
          alu_delay = -1;
        end
      end
    end
    prev_wr  = WrEn;
    prev_rd  = RdEn;
    prev_alu = ALU_EN;
    prev_tx  = TX_D_VLD;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(negedge clk);
    RX_D_VLD = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || TX_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk({tag, "_drain_timeout"}, sb_q.size(), 32'h0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_strobes", {28'h0, WrEn, RdEn, ALU_EN, TX_D_VLD}, 32'h0);
    chk("rst_addr",    {28'h0, Address}, 32'h0);
    chk("rst_wrdata",  {24'h0, WrData}, 32'h0);
    chk("rst_alufun",  {28'h0, ALU_FUN}, 32'h0);
    chk("rst_txdata",  {24'h0, TX_P_DATA}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // register write
    sb_q.push_back(ev(K_WR, 8'h05, 16'h003C));
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    wait_drain("write");

    // register read with one-byte reply
    rd_reply = 8'h9E;
    sb_q.push_back(ev(K_RD, 8'h07, 16'h0000));
    sb_q.push_back(ev(K_TX, 8'h00, 16'h009E));
    send_byte(8'hBB); send_byte(8'h07);
    wait_drain("read");

    // full ALU command, two-byte reply low first
    alu_reply = 16'h0046;
    sb_q.push_back(ev(K_WR, 8'h00, 16'h0012));
    sb_q.push_back(ev(K_WR, 8'h01, 16'h0034));
    sb_q.push_back(ev(K_ALU, 8'h00, 16'h0000));
    sb_q.push_back(ev(K_TX, 8'h00, 16'h0046));
    sb_q.push_back(ev(K_TX, 8'h00, 16'h0000));
    foreach (sb_q[i]) begin end
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    wait_drain("alu");

    // unknown opcode discarded
    sb_q.push_back(ev(K_WR, 8'h01, 16'h00FF));
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    wait_drain("bad_op");

    // reset abandons a half-sent write
    send_byte(8'hAA); send_byte(8'h03);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_strobes", {28'h0, WrEn, RdEn, ALU_EN, TX_D_VLD}, 32'h0);
    @(negedge clk);
    chk("post_rst_strobes", {28'h0, WrEn, RdEn, ALU_EN, TX_D_VLD}, 32'h0);
    send_byte(8'h3C);
    alu_reply = 16'h1234;
    sb_q.push_back(ev(K_ALU, 8'h00, 16'h0002));
    sb_q.push_back(ev(K_TX, 8'h00, 16'h0034));
    sb_q.push_back(ev(K_TX, 8'h00, 16'h0012));
    send_byte(8'hDD); send_byte(8'h02);
    wait_drain("rst_abandon");

    // bytes arriving during ALU_WAIT are dropped
    alu_reply = 16'hBEEF;
    sb_q.push_back(ev(K_WR, 8'h00, 16'h0011));
    sb_q.push_back(ev(K_WR, 8'h01, 16'h0022));
    sb_q.push_back(ev(K_ALU, 8'h00, 16'h0003));
    sb_q.push_back(ev(K_TX, 8'h00, 16'h00EF));
    sb_q.push_back(ev(K_TX, 8'h00, 16'h00BE));
    send_byte(8'hCC); send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
    send_byte(8'hBB); send_byte(8'h07);
    wait_drain("drop_busy");
    repeat (20) @(negedge clk);

    chk("sb_empty", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
